mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and AXI-side signals of the memory bus arbiter.
// The master modport is the arbiter's view. The slave modport is the view
// shared by the requesters and the AXI slave.
interface mem_bus_arbiter_if #(parameter int LINE_WORDS = 4);
  logic                      ic_rd_req, dc_rd_req, uc_rd_req;
  logic [2:0]                ic_rd_type, dc_rd_type, uc_rd_type;
  logic [31:0]               ic_rd_addr, dc_rd_addr, uc_rd_addr;
  logic                      ic_rd_rdy, dc_rd_rdy, uc_rd_rdy;
  logic                      ic_ret_valid, dc_ret_valid, uc_ret_valid;
  logic                      ret_last;
  logic [31:0]               ret_data;
  logic                      dc_wr_req, uc_wr_req;
  logic [2:0]                dc_wr_type, uc_wr_type;
  logic [31:0]               dc_wr_addr, uc_wr_addr;
  logic [3:0]                dc_wr_wstrb, uc_wr_wstrb;
  logic [32*LINE_WORDS-1:0]  dc_wr_data, uc_wr_data;
  logic                      dc_wr_rdy, uc_wr_rdy;
  logic [3:0]  arid;   logic [31:0] araddr; logic [7:0] arlen;
  logic [2:0]  arsize; logic [1:0]  arburst; logic arvalid, arready;
  logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
  logic        rlast,  rvalid, rready;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [7:0] awlen;
  logic [2:0]  awsize; logic [1:0]  awburst; logic awvalid, awready;
  logic [3:0]  wid;    logic [31:0] wdata;  logic [3:0] wstrb;
  logic        wlast,  wvalid, wready;
  logic [3:0]  bid;    logic [1:0]  bresp;  logic bvalid, bready;

  modport master (
    input  ic_rd_req, dc_rd_req, uc_rd_req, ic_rd_type, dc_rd_type, uc_rd_type,
           ic_rd_addr, dc_rd_addr, uc_rd_addr,
           dc_wr_req, uc_wr_req, dc_wr_type, uc_wr_type, dc_wr_addr, uc_wr_addr,
           dc_wr_wstrb, uc_wr_wstrb, dc_wr_data, uc_wr_data,
           arready, rid, rdata, rresp, rlast, rvalid, awready, wready,
           bid, bresp, bvalid,
    output ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, ic_ret_valid, dc_ret_valid, uc_ret_valid,
           ret_last, ret_data, dc_wr_rdy, uc_wr_rdy,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output ic_rd_req, dc_rd_req, uc_rd_req, ic_rd_type, dc_rd_type, uc_rd_type,
           ic_rd_addr, dc_rd_addr, uc_rd_addr,
           dc_wr_req, uc_wr_req, dc_wr_type, uc_wr_type, dc_wr_addr, uc_wr_addr,
           dc_wr_wstrb, uc_wr_wstrb, dc_wr_data, uc_wr_data,
           arready, rid, rdata, rresp, rlast, rvalid, awready, wready,
           bid, bresp, bvalid,
    input  ic_rd_rdy, dc_rd_rdy, uc_rd_rdy, ic_ret_valid, dc_ret_valid, uc_ret_valid,
           ret_last, ret_data, dc_wr_rdy, uc_wr_rdy,
           arid, araddr, arlen, arsize, arburst, arvalid, rready,
           awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one AXI bus between the icache, dcache and uncached ports.
// It allows one outstanding read and one outstanding write. Read returns are
// steered back to the requester that issued the read. A read that hits the
// line of an in-flight write is held off until that write's B response arrives.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             resetn,
  mem_bus_arbiter_if.master bus
);
  localparam int         OFF      = $clog2(4 * LINE_WORDS);
  localparam int         CW       = $clog2(LINE_WORDS);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);
  localparam logic [1:0] OWN_IC = 2'd0, OWN_DC = 2'd1, OWN_UC = 2'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B}   w_state_e;

  r_state_e                 r_state_q, r_state_d;
  logic [31:0]              r_addr_q, r_addr_d;
  logic [2:0]               r_type_q, r_type_d;
  logic [1:0]               r_owner_q, r_owner_d;

  w_state_e                 w_state_q, w_state_d;
  logic [31:0]              w_addr_q, w_addr_d;
  logic [2:0]               w_type_q, w_type_d;
  logic [32*LINE_WORDS-1:0] w_data_q, w_data_d;
  logic [3:0]               w_strb_q, w_strb_d;
  logic [CW-1:0]            w_cnt_q, w_cnt_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;

  // Response ids and codes carry nothing the arbiter acts on.
  logic unused_resp;
  assign unused_resp = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

  // Line-address hazard against the write currently in flight.
  logic w_busy, ic_blk, dc_blk, uc_blk;
  assign w_busy = (w_state_q != W_IDLE);
  assign ic_blk = w_busy && (bus.ic_rd_addr[31:OFF] == w_addr_q[31:OFF]);
  assign dc_blk = w_busy && (bus.dc_rd_addr[31:OFF] == w_addr_q[31:OFF]);
  assign uc_blk = w_busy && (bus.uc_rd_addr[31:OFF] == w_addr_q[31:OFF]);

  // Read grant uc > dc > ic. A blocked requester does not stall the ones below it.
  logic r_idle, uc_rd_win, dc_rd_win, ic_rd_win, rd_acc;
  always_comb begin
    r_idle    = resetn && (r_state_q == R_IDLE);
    uc_rd_win = bus.uc_rd_req && !uc_blk;
    dc_rd_win = bus.dc_rd_req && !dc_blk && !uc_rd_win;
    ic_rd_win = bus.ic_rd_req && !ic_blk && !uc_rd_win && !dc_rd_win;
    rd_acc    = r_idle && (uc_rd_win || dc_rd_win || ic_rd_win);
  end

  // Write grant uc > dc. Writes are not subject to the hazard check.
  logic w_idle, uc_wr_win, dc_wr_win, wr_acc;
  always_comb begin
    w_idle    = resetn && (w_state_q == W_IDLE);
    uc_wr_win = bus.uc_wr_req;
    dc_wr_win = bus.dc_wr_req && !bus.uc_wr_req;
    wr_acc    = w_idle && (uc_wr_win || dc_wr_win);
  end

  // Read FSM state and the request latched at grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_type_q  <= '0;
      r_owner_q <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_type_q  <= r_type_d;
      r_owner_q <= r_owner_d;
    end
  end

  // Read next state: grant, address phase, then data beats until rlast.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_type_d  = r_type_q;
    r_owner_d = r_owner_q;
    case (r_state_q)
      R_IDLE: if (rd_acc) begin
        r_state_d = R_AR;
        if (uc_rd_win) begin
          r_addr_d = bus.uc_rd_addr; r_type_d = bus.uc_rd_type; r_owner_d = OWN_UC;
        end else if (dc_rd_win) begin
          r_addr_d = bus.dc_rd_addr; r_type_d = bus.dc_rd_type; r_owner_d = OWN_DC;
        end else begin
          r_addr_d = bus.ic_rd_addr; r_type_d = bus.ic_rd_type; r_owner_d = OWN_IC;
        end
      end
      R_AR:    if (bus.arready) r_state_d = R_DATA;
      R_DATA:  if (bus.rvalid && bus.rlast) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read outputs: AR channel from the latched request, R beats to the owner only.
  logic in_data;
  always_comb begin
    in_data          = (r_state_q == R_DATA);
    bus.ic_rd_rdy    = r_idle && ic_rd_win;
    bus.dc_rd_rdy    = r_idle && dc_rd_win;
    bus.uc_rd_rdy    = r_idle && uc_rd_win;
    bus.arvalid      = (r_state_q == R_AR);
    bus.araddr       = r_addr_q;
    bus.arlen        = r_type_q[2] ? LINE_LEN : 8'd0;
    bus.arsize       = r_type_q[2] ? 3'd2 : {1'b0, r_type_q[1:0]};
    bus.arburst      = 2'b01;
    bus.arid         = {2'b00, r_owner_q};
    bus.rready       = in_data;
    bus.ic_ret_valid = in_data && bus.rvalid && (r_owner_q == OWN_IC);
    bus.dc_ret_valid = in_data && bus.rvalid && (r_owner_q == OWN_DC);
    bus.uc_ret_valid = in_data && bus.rvalid && (r_owner_q == OWN_UC);
    bus.ret_last     = in_data && bus.rvalid && bus.rlast;
    bus.ret_data     = in_data ? bus.rdata : 32'd0;
  end

  // Write FSM state, the latched request and the beat counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_type_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_cnt_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_type_q  <= w_type_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      w_cnt_q   <= w_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // The AW and W channels run independently; W_REQ is left only after both finish.
  logic [7:0] w_len;
  logic       aw_hs, w_hs, w_last;
  always_comb begin
    w_len  = w_type_q[2] ? LINE_LEN : 8'd0;
    w_last = (8'(w_cnt_q) == w_len);
    aw_hs  = (w_state_q == W_REQ) && !aw_done_q && bus.awready;
    w_hs   = (w_state_q == W_REQ) && !w_done_q && bus.wready;
  end

  // Write next state.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_type_d  = w_type_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    w_cnt_d   = w_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (w_state_q)
      W_IDLE: if (wr_acc) begin
        w_state_d = W_REQ;
        w_cnt_d   = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (uc_wr_win) begin
          w_addr_d = bus.uc_wr_addr; w_type_d = bus.uc_wr_type; w_data_d = bus.uc_wr_data;
          w_strb_d = bus.uc_wr_type[2] ? 4'hf : bus.uc_wr_wstrb;
        end else begin
          w_addr_d = bus.dc_wr_addr; w_type_d = bus.dc_wr_type; w_data_d = bus.dc_wr_data;
          w_strb_d = bus.dc_wr_type[2] ? 4'hf : bus.dc_wr_wstrb;
        end
      end
      W_REQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          if (w_last) w_done_d = 1'b1;
          else        w_cnt_d  = w_cnt_q + CW'(1);
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last))) w_state_d = W_B;
      end
      W_B:     if (bus.bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write outputs: the beat counter selects the current data word.
  always_comb begin
    bus.dc_wr_rdy = w_idle && dc_wr_win;
    bus.uc_wr_rdy = w_idle && uc_wr_win;
    bus.awvalid   = (w_state_q == W_REQ) && !aw_done_q;
    bus.awaddr    = w_addr_q;
    bus.awlen     = w_len;
    bus.awsize    = w_type_q[2] ? 3'd2 : {1'b0, w_type_q[1:0]};
    bus.awburst   = 2'b01;
    bus.awid      = 4'd1;
    bus.wvalid    = (w_state_q == W_REQ) && !w_done_q;
    bus.wdata     = w_data_q[w_cnt_q*32 +: 32];
    bus.wstrb     = w_strb_q;
    bus.wlast     = w_last;
    bus.wid       = 4'd1;
    bus.bready    = (w_state_q == W_B);
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. The stimulus pushes the expected AR/AW
// fields, W beats and return beats into queues. A negedge monitor compares
// each of them whenever the DUT presents it.
module tb_mem_bus_arbiter;
  localparam int LW = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.LINE_WORDS(LW)) bus();
  mem_bus_arbiter #(.LINE_WORDS(LW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_pass = 0;
  int n_tot  = 0;
  logic [63:0] ar_q[$], ret_q[$], aw_q[$], w_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [63:0] ax_e(logic [3:0] id, logic [31:0] a, logic [7:0] len, logic [2:0] sz);
    return {15'd0, id, a, len, sz, 2'b01};
  endfunction
  function automatic logic [63:0] ret_e(logic [2:0] who, logic [31:0] d, logic l);
    return {28'd0, who, d, l};
  endfunction
  function automatic logic [63:0] w_e(logic [31:0] d, logic [3:0] s, logic l);
    return {23'd0, 4'd1, d, s, l};
  endfunction
  function automatic logic [45:0] outs();
    return {bus.ic_rd_rdy, bus.dc_rd_rdy, bus.uc_rd_rdy, bus.dc_wr_rdy, bus.uc_wr_rdy,
            bus.ic_ret_valid, bus.dc_ret_valid, bus.uc_ret_valid, bus.arvalid, bus.awvalid,
            bus.wvalid, bus.rready, bus.bready, bus.ret_last, bus.ret_data};
  endfunction

  // Monitor: comparing every cycle while valid is high also checks that the fields stay stable.
  always @(negedge clk) if (resetn) begin
    if (bus.arvalid) begin
      if (ar_q.size() == 0) chk("ar_unexpected", 64'(ar_q.size()), 64'd1);
      else begin
        chk("ar_fields", {15'd0, bus.arid, bus.araddr, bus.arlen, bus.arsize, bus.arburst}, ar_q[0]);
        if (bus.arready) void'(ar_q.pop_front());
      end
    end
    if (bus.ic_ret_valid || bus.dc_ret_valid || bus.uc_ret_valid) begin
      if (ret_q.size() == 0) chk("ret_unexpected", 64'(ret_q.size()), 64'd1);
      else chk("ret_beat", {28'd0, bus.ic_ret_valid, bus.dc_ret_valid, bus.uc_ret_valid,
                            bus.ret_data, bus.ret_last}, ret_q.pop_front());
    end
    if (bus.awvalid) begin
      if (aw_q.size() == 0) chk("aw_unexpected", 64'(aw_q.size()), 64'd1);
      else begin
        chk("aw_fields", {15'd0, bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst}, aw_q[0]);
        if (bus.awready) void'(aw_q.pop_front());
      end
    end
    if (bus.wvalid) begin
      if (w_q.size() == 0) chk("w_unexpected", 64'(w_q.size()), 64'd1);
      else begin
        chk("w_beat", {23'd0, bus.wid, bus.wdata, bus.wstrb, bus.wlast}, w_q[0]);
        if (bus.wready) void'(w_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // AXI read slave: accept the AR, then return nb beats of base+i. Call this at posedge+1.
  task automatic serve_read(input int nb, input logic [31:0] base);
    for (int i = 0; i < 20 && !bus.arvalid; i++) tick();
    chk("ar_seen", 64'(bus.arvalid), 64'd1);
    bus.arready = 1'b1; tick(); bus.arready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bus.rvalid = 1'b1; bus.rdata = base + 32'(b); bus.rlast = (b == nb - 1); tick();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  // AXI write slave: awready is held low for aw_delay cycles; wready optionally toggles. Call this at posedge+1.
  task automatic serve_write(input int nb, input int aw_delay, input bit toggle);
    int beats = 0;
    bit awd = 1'b0;
    bit hs_aw, hs_w;
    for (int c = 0; c < 40 && !(awd && beats == nb); c++) begin
      bus.awready = (c >= aw_delay) && !awd;
      bus.wready  = toggle ? ((c % 2) == 1) : 1'b1;
      @(negedge clk);
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      tick();
      if (hs_aw) awd = 1'b1;
      if (hs_w) beats++;
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("wr_phase_done", 64'(awd && beats == nb), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    {bus.ic_rd_req, bus.dc_rd_req, bus.uc_rd_req, bus.dc_wr_req, bus.uc_wr_req} = '1;
    {bus.ic_rd_type, bus.dc_rd_type, bus.uc_rd_type, bus.dc_wr_type, bus.uc_wr_type} = '0;
    {bus.ic_rd_addr, bus.dc_rd_addr, bus.uc_rd_addr, bus.dc_wr_addr, bus.uc_wr_addr} = '0;
    {bus.dc_wr_wstrb, bus.uc_wr_wstrb} = '0;
    bus.dc_wr_data = '0; bus.uc_wr_data = '0;
    {bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rlast} = '0;
    bus.rvalid = 1'b1; bus.rdata = 32'hdead_beef;
    {bus.rid, bus.rresp, bus.bid, bus.bresp} = '0;

    // Reset: outputs are idle even with every request and rvalid asserted.
    tick(); @(negedge clk);
    chk("reset_outputs", 64'(outs()), 64'd0);
    {bus.ic_rd_req, bus.dc_rd_req, bus.uc_rd_req, bus.dc_wr_req, bus.uc_wr_req} = '0;
    bus.rvalid = 1'b0;
    tick(); resetn = 1'b1; tick();

    // Line read from ic.
    bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = 32'h1fc0_0010;
    @(negedge clk); chk("ic_rd_rdy", 64'(bus.ic_rd_rdy), 64'd1);
    ar_q.push_back(ax_e(4'd0, 32'h1fc0_0010, 8'd3, 3'd2));
    for (int i = 0; i < 4; i++) ret_q.push_back(ret_e(3'b100, 32'h1000_0000 + 32'(i), i == 3));
    tick(); bus.ic_rd_req = 1'b0;
    serve_read(4, 32'h1000_0000);

    // dc wins over ic; ic is granted in the first idle cycle after dc's rlast.
    bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = 32'h1fc0_0020;
    bus.dc_rd_req = 1'b1; bus.dc_rd_type = 3'b010; bus.dc_rd_addr = 32'h0000_0104;
    @(negedge clk);
    chk("prio_dc_rdy", 64'(bus.dc_rd_rdy), 64'd1);
    chk("prio_ic_wait", 64'(bus.ic_rd_rdy), 64'd0);
    ar_q.push_back(ax_e(4'd1, 32'h0000_0104, 8'd0, 3'd2));
    ret_q.push_back(ret_e(3'b010, 32'h3000_0000, 1'b1));
    ar_q.push_back(ax_e(4'd0, 32'h1fc0_0020, 8'd3, 3'd2));
    for (int i = 0; i < 4; i++) ret_q.push_back(ret_e(3'b100, 32'h4000_0000 + 32'(i), i == 3));
    tick(); bus.dc_rd_req = 1'b0;
    @(negedge clk); chk("busy_ic_wait", 64'(bus.ic_rd_rdy), 64'd0);
    tick();
    serve_read(1, 32'h3000_0000);
    @(negedge clk); chk("ic_after_rlast", 64'(bus.ic_rd_rdy), 64'd1);
    tick(); bus.ic_rd_req = 1'b0;
    serve_read(4, 32'h4000_0000);

    // Uncached halfword write; uc_wr_rdy stays low until the B handshake.
    bus.uc_wr_req = 1'b1; bus.uc_wr_type = 3'b001; bus.uc_wr_addr = 32'h1faf_0002;
    bus.uc_wr_wstrb = 4'b1100; bus.uc_wr_data = '0; bus.uc_wr_data[31:0] = 32'haabb_0000;
    @(negedge clk); chk("uc_wr_rdy", 64'(bus.uc_wr_rdy), 64'd1);
    aw_q.push_back(ax_e(4'd1, 32'h1faf_0002, 8'd0, 3'd1));
    w_q.push_back(w_e(32'haabb_0000, 4'b1100, 1'b1));
    tick();
    @(negedge clk); chk("uc_wr_busy", 64'(bus.uc_wr_rdy), 64'd0);
    tick();
    serve_write(1, 0, 1'b0);
    @(negedge clk);
    chk("uc_wr_wait_b", 64'(bus.uc_wr_rdy), 64'd0);
    chk("bready_uc", 64'(bus.bready), 64'd1);
    bus.bvalid = 1'b1; tick(); bus.bvalid = 1'b0;
    @(negedge clk); chk("uc_wr_free", 64'(bus.uc_wr_rdy), 64'd1);
    bus.uc_wr_req = 1'b0;
    tick();

    // dc line write with a slow AW. The read of the same line waits; a read of another line goes ahead.
    bus.dc_wr_req = 1'b1; bus.dc_wr_type = 3'b100; bus.dc_wr_addr = 32'h0000_1000;
    bus.dc_wr_wstrb = 4'b0001;
    bus.dc_wr_data = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
    @(negedge clk); chk("dc_wr_rdy", 64'(bus.dc_wr_rdy), 64'd1);
    aw_q.push_back(ax_e(4'd1, 32'h0000_1000, 8'd3, 3'd2));
    for (int i = 0; i < 4; i++) w_q.push_back(w_e(32'h1111_0000 + 32'(i), 4'hf, i == 3));
    tick(); bus.dc_wr_req = 1'b0;
    bus.dc_rd_req = 1'b1; bus.dc_rd_type = 3'b010; bus.dc_rd_addr = 32'h0000_100c;
    bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b010; bus.ic_rd_addr = 32'h0000_2000;
    @(negedge clk);
    chk("hazard_dc_blocked", 64'(bus.dc_rd_rdy), 64'd0);
    chk("hazard_ic_pass", 64'(bus.ic_rd_rdy), 64'd1);
    ar_q.push_back(ax_e(4'd0, 32'h0000_2000, 8'd0, 3'd2));
    ret_q.push_back(ret_e(3'b100, 32'h5000_0000, 1'b1));
    tick(); bus.ic_rd_req = 1'b0;
    fork
      serve_read(1, 32'h5000_0000);
      serve_write(4, 3, 1'b0);
    join
    @(negedge clk);
    chk("hazard_hold", 64'(bus.dc_rd_rdy), 64'd0);
    chk("bready_dc", 64'(bus.bready), 64'd1);
    bus.bvalid = 1'b1; tick(); bus.bvalid = 1'b0;
    @(negedge clk); chk("hazard_release", 64'(bus.dc_rd_rdy), 64'd1);
    ar_q.push_back(ax_e(4'd1, 32'h0000_100c, 8'd0, 3'd2));
    ret_q.push_back(ret_e(3'b010, 32'h6000_0000, 1'b1));
    tick(); bus.dc_rd_req = 1'b0;
    serve_read(1, 32'h6000_0000);

    // dc line write with wready toggling: words come out in order, with wlast on the fourth.
    bus.dc_wr_req = 1'b1; bus.dc_wr_addr = 32'h0000_3000;
    bus.dc_wr_data = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
    @(negedge clk); chk("dc_wr_rdy2", 64'(bus.dc_wr_rdy), 64'd1);
    aw_q.push_back(ax_e(4'd1, 32'h0000_3000, 8'd3, 3'd2));
    for (int i = 0; i < 4; i++) w_q.push_back(w_e(32'h2222_0000 + 32'(i), 4'hf, i == 3));
    tick(); bus.dc_wr_req = 1'b0;
    serve_write(4, 0, 1'b1);
    bus.bvalid = 1'b1; tick(); bus.bvalid = 1'b0;

    // Reset during the second read beat; no stale return after release.
    bus.ic_rd_req = 1'b1; bus.ic_rd_type = 3'b100; bus.ic_rd_addr = 32'h1fc0_0040;
    @(negedge clk); chk("ic_rd_rdy2", 64'(bus.ic_rd_rdy), 64'd1);
    ar_q.push_back(ax_e(4'd0, 32'h1fc0_0040, 8'd3, 3'd2));
    ret_q.push_back(ret_e(3'b100, 32'h7000_0000, 1'b0));
    tick(); bus.ic_rd_req = 1'b0;
    bus.arready = 1'b1; tick(); bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h7000_0000; bus.rlast = 1'b0; tick();
    bus.rdata = 32'h7000_0001; resetn = 1'b0; #1;
    chk("rst_abort_outputs", 64'(outs()), 64'd0);
    tick(); resetn = 1'b1;
    @(negedge clk);
    chk("no_stale_ret", 64'({bus.ic_ret_valid, bus.dc_ret_valid, bus.uc_ret_valid, bus.rready}), 64'd0);
    tick(); @(negedge clk);
    chk("no_stale_ret2", 64'({bus.ic_ret_valid, bus.dc_ret_valid, bus.uc_ret_valid, bus.rready}), 64'd0);
    bus.rvalid = 1'b0;
    tick();
    bus.dc_rd_req = 1'b1; bus.dc_rd_type = 3'b010; bus.dc_rd_addr = 32'h0000_0200;
    @(negedge clk); chk("post_rst_rdy", 64'(bus.dc_rd_rdy), 64'd1);
    ar_q.push_back(ax_e(4'd1, 32'h0000_0200, 8'd0, 3'd2));
    ret_q.push_back(ret_e(3'b010, 32'h8000_0000, 1'b1));
    tick(); bus.dc_rd_req = 1'b0;
    serve_read(1, 32'h8000_0000);
    tick(); tick();

    chk("ar_q_drained",  64'(ar_q.size()),  64'd0);
    chk("ret_q_drained", 64'(ret_q.size()), 64'd0);
    chk("aw_q_drained",  64'(aw_q.size()),  64'd0);
    chk("w_q_drained",   64'(w_q.size()),   64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
